rca_lsq: RTL and testbench
==========================

Name: rca_lsq

Overview:
- Load/store queue between the RCA grid's memory-access rows and the shared Taiga LSU.
- Accepts up to GRID_NUM_ROWS load/store requests per cycle from grid rows and serialises them, in order, into one-at-a-time LSU requests.
- Holds the LSU lock while it has work.
- Routes each load result back to the grid row that requested it.

Parameters:
- GRID_NUM_ROWS, 4, number of grid rows that can issue memory requests (from rca_config).
- LSQ_DEPTH, 8, queue entries; power of two, must be ≥ 2*GRID_NUM_ROWS.
- XLEN, 32, data/address width (from taiga_config).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- grid_addr  in  XLEN x GRID_NUM_ROWS  effective address per row
- grid_data  in  XLEN x GRID_NUM_ROWS  store data per row
- grid_fn3  in  3 x GRID_NUM_ROWS  RISC-V width/sign code per row
- grid_load  in  1 x GRID_NUM_ROWS  row request is a load
- grid_store  in  1 x GRID_NUM_ROWS  row request is a store
- grid_new_request  in  1 x GRID_NUM_ROWS  row pushes a request this cycle
- grid_fifo_full  out  1  grid must not push
- grid_load_complete  out  1 x GRID_NUM_ROWS  one-cycle pulse, load data valid for that row
- grid_load_data  out  XLEN  returned load data, shared by all rows
- lsu_rs1  out  XLEN  request address
- lsu_rs2  out  XLEN  store data
- lsu_fn3  out  3  width code
- lsu_load  out  1  one-cycle load issue pulse
- lsu_store  out  1  one-cycle store issue pulse
- lsu_lock  out  1  RCA owns the LSU
- lsu_ready  in  1  LSU can accept a request this cycle
- lsu_load_complete  in  1  LSU load result valid
- lsu_load_data  in  XLEN  LSU load result

Behaviour:
- Reset (async, rst_n=0):
  - Queue is empty: head = tail = count = 0.
  - load_pending = 0, lsu_lock = 0, grid_fifo_full = 0.
  - All grid_load_complete = 0, grid_load_data = 0.
  - lsu_load and lsu_store = 0.
  - Reset mid-operation discards queued entries and any pending load; a late lsu_load_complete after reset is ignored.
- Entry format: {addr, data, fn3, is_store, row_idx}. is_load is implied by !is_store.
- Enqueue:
  - Rows with grid_new_request=1 are written in the same cycle in ascending row index, at tail, tail+1, ...
  - count and tail advance by popcount(grid_new_request). Pointers wrap modulo LSQ_DEPTH.
- Full: grid_fifo_full = (LSQ_DEPTH - count) < GRID_NUM_ROWS, registered from next-state count. A full row set can therefore always be absorbed.
- Push while grid_fifo_full=1 is a grid protocol violation: simulation assertion fires; overflowing rows are dropped.
- Lock:
  - lsu_lock is registered: lsu_lock <= (count_next != 0) | load_pending_next.
  - lsu_lock falls the cycle after the queue drains and the last load returns.
- Issue:
  - issue = (count != 0) & lsu_lock & lsu_ready & !load_pending.
  - lsu_rs1/rs2/fn3 are driven combinationally from the head entry.
  - lsu_load = issue & !head.is_store; lsu_store = issue & head.is_store.
  - On issue: head and count decrement. A load also sets load_pending and pending_row <= head.row_idx.
- Latency: a request pushed at cycle N issues no earlier than N+1.
- Ordering: strict FIFO order, both between rows of one cycle (ascending index) and across cycles. Only one load is outstanding; stores behind it wait.
- Load return:
  - On lsu_load_complete with load_pending=1: next cycle grid_load_complete[pending_row] pulses for one cycle and grid_load_data <= lsu_load_data. load_pending clears the same edge.
  - A new issue is allowed in the cycle after return.
  - lsu_load_complete with load_pending=0: ignored, assertion fires.
- Simultaneous push and issue: count_next = count + pushes - issue. Push into the slot freed by the issue is legal.
- grid_load_data holds its last value between pulses.

Decomposition:
- rca_config gains: LSQ_DEPTH; typedef rca_lsq_entry_t (addr, data, fn3, is_store, row_idx of $clog2(GRID_NUM_ROWS) bits); typedef row_idx_t.
- One natural sub-module, rca_lsq_compactor: combinational prefix-popcount over grid_new_request that produces each row's write offset and the total push count.
- Storage, pointers, issue and return logic live in rca_lsq.

Test Plan:
1. Reset with queue holding 3 entries, then release → lsu_lock=0, count=0, no lsu_load/lsu_store pulses, grid_fifo_full=0.
2. Rows 0,2 push in one cycle (row0 store addr 0x100 data 0xAA, row2 load addr 0x200) with lsu_ready=1:
   - lsu_lock high at N+1.
   - Store issues at N+1 with rs1=0x100, rs2=0xAA; load issues at N+2 with rs1=0x200.
   - Return data 0x1234 → grid_load_complete[2] pulses once and grid_load_data=0x1234.
3. All 4 rows push on 2 consecutive cycles with lsu_ready=0 → count=8, grid_fifo_full=1 after the first push (free 4 ≥ 4 → 0, after second 0 < 4 → 1). Assert lsu_ready → FIFO order 0..3,0..3 on the LSU.
4. Two loads queued, rows 1 and 3; LSU returns the first after 5 cycles → second load not issued before the return cycle +1; completions arrive on rows 1 then 3.
5. Push 4 rows on the same cycle that the head issues at count=4 (LSQ_DEPTH=8) → count=7, no overflow assertion, pointers wrap correctly.
6. Spurious lsu_load_complete with no pending load → no grid_load_complete pulse, assertion fires.

Source files
------------

// File: rtl/rca_lsq_pkg.sv
// Shared sizing, entry layout and index types for the RCA load/store queue.
package rca_lsq_pkg;

  localparam int GRID_NUM_ROWS = 4;
  localparam int LSQ_DEPTH     = 8;
  localparam int XLEN          = 32;

  localparam int ROW_W = $clog2(GRID_NUM_ROWS);
  localparam int PTR_W = $clog2(LSQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            is_store;
    row_idx_t        row_idx;
  } rca_lsq_entry_t;

endpackage

// File: rtl/rca_lsq_compactor.sv
// Prefix popcount over the row request vector: each row's slot offset from
// tail, plus the total number of rows pushing this cycle.
module rca_lsq_compactor
  import rca_lsq_pkg::*;
(
  input  logic [GRID_NUM_ROWS-1:0]       req,
  output cnt_t [GRID_NUM_ROWS-1:0]       offset,
  output cnt_t                           total
);

  always_comb begin
    total  = '0;
    offset = '0;
    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      offset[r] = total;
      total     = total + cnt_t'(req[r]);
    end
  end

endmodule

// File: rtl/rca_lsq.sv
// Load/store queue: absorbs up to one request per grid row per cycle and
// issues them in order to the shared LSU, one load outstanding at a time.
module rca_lsq
  import rca_lsq_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_addr,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_data,
  input  logic [GRID_NUM_ROWS-1:0][2:0]      grid_fn3,
  input  logic [GRID_NUM_ROWS-1:0]           grid_load,
  input  logic [GRID_NUM_ROWS-1:0]           grid_store,
  input  logic [GRID_NUM_ROWS-1:0]           grid_new_request,
  output logic                               grid_fifo_full,
  output logic [GRID_NUM_ROWS-1:0]           grid_load_complete,
  output logic [XLEN-1:0]                    grid_load_data,
  output logic [XLEN-1:0]                    lsu_rs1,
  output logic [XLEN-1:0]                    lsu_rs2,
  output logic [2:0]                         lsu_fn3,
  output logic                               lsu_load,
  output logic                               lsu_store,
  output logic                               lsu_lock,
  input  logic                               lsu_ready,
  input  logic                               lsu_load_complete,
  input  logic [XLEN-1:0]                    lsu_load_data
);

  rca_lsq_entry_t mem [LSQ_DEPTH];
  rca_lsq_entry_t head_entry;
  ptr_t           head, tail;
  cnt_t           count, count_next;
  cnt_t           push_total, free_slots, pushes;
  cnt_t [GRID_NUM_ROWS-1:0] offset;
  logic [GRID_NUM_ROWS-1:0] accept;
  logic           issue;
  logic           load_pending, load_pending_next;
  row_idx_t       pending_row;

  rca_lsq_compactor u_compactor (
    .req    (grid_new_request),
    .offset (offset),
    .total  (push_total)
  );

  assign head_entry = mem[head];

  // LSU handshake: a request transfers in any cycle where lsu_load or
  // lsu_store is high; both only rise while lsu_ready is high, so the LSU
  // never has to hold a request and there is no stall path back to the queue.
  assign issue     = (count != '0) && lsu_lock && lsu_ready && !load_pending;
  assign lsu_rs1   = head_entry.addr;
  assign lsu_rs2   = head_entry.data;
  assign lsu_fn3   = head_entry.fn3;
  assign lsu_load  = issue && !head_entry.is_store;
  assign lsu_store = issue && head_entry.is_store;

  // The head slot freed by an issue this cycle may be refilled by a push.
  assign free_slots = cnt_t'(LSQ_DEPTH) - count + cnt_t'(issue);
  assign pushes     = (push_total < free_slots) ? push_total : free_slots;
  assign count_next = count + pushes - cnt_t'(issue);

  always_comb begin
    accept = '0;
    for (int r = 0; r < GRID_NUM_ROWS; r++)
      accept[r] = grid_new_request[r] && (offset[r] < free_slots);
  end

  always_comb begin
    load_pending_next = load_pending;
    if (lsu_load_complete) load_pending_next = 1'b0;
    if (lsu_load)          load_pending_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      if (accept[r]) begin
        mem[tail + ptr_t'(offset[r])] <= '{addr:     grid_addr[r],
                                           data:     grid_data[r],
                                           fn3:      grid_fn3[r],
                                           is_store: grid_store[r],
                                           row_idx:  row_idx_t'(r)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      load_pending       <= 1'b0;
      pending_row        <= '0;
      lsu_lock           <= 1'b0;
      grid_fifo_full     <= 1'b0;
      grid_load_complete <= '0;
      grid_load_data     <= '0;
    end else begin
      tail           <= tail + ptr_t'(pushes);
      count          <= count_next;
      load_pending   <= load_pending_next;
      lsu_lock       <= (count_next != '0) || load_pending_next;
      grid_fifo_full <= (cnt_t'(LSQ_DEPTH) - count_next) < cnt_t'(GRID_NUM_ROWS);
      if (issue) head <= head + ptr_t'(1);
      if (lsu_load) pending_row <= head_entry.row_idx;
      grid_load_complete <= '0;
      if (lsu_load_complete && load_pending) begin
        grid_load_complete[pending_row] <= 1'b1;
        grid_load_data                  <= lsu_load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(grid_fifo_full && (grid_new_request != '0)))
        else $warning("rca_lsq: grid pushed while queue full, rows dropped");
      assert ((grid_new_request & ~(grid_load ^ grid_store)) == '0)
        else $warning("rca_lsq: row request is not exactly one of load/store");
      assert (!(lsu_load_complete && !load_pending))
        else $warning("rca_lsq: lsu_load_complete with no load pending");
    end
  end

endmodule

// File: tb/tb_rca_lsq.sv
// Scoreboarded bench for rca_lsq with a behavioural LSU responder.
module tb_rca_lsq;
  import rca_lsq_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst_n = 1'b0;
  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_addr = '0;
  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_data = '0;
  logic [GRID_NUM_ROWS-1:0][2:0]      grid_fn3 = '0;
  logic [GRID_NUM_ROWS-1:0]           grid_load = '0;
  logic [GRID_NUM_ROWS-1:0]           grid_store = '0;
  logic [GRID_NUM_ROWS-1:0]           grid_new_request = '0;
  logic                               grid_fifo_full;
  logic [GRID_NUM_ROWS-1:0]           grid_load_complete;
  logic [XLEN-1:0]                    grid_load_data;
  logic [XLEN-1:0]                    lsu_rs1, lsu_rs2;
  logic [2:0]                         lsu_fn3;
  logic                               lsu_load, lsu_store, lsu_lock;
  logic                               lsu_ready = 1'b0;
  logic                               lsu_load_complete = 1'b0;
  logic [XLEN-1:0]                    lsu_load_data = '0;

  rca_lsq dut (
    .clk(clk), .rst_n(rst_n),
    .grid_addr(grid_addr), .grid_data(grid_data), .grid_fn3(grid_fn3),
    .grid_load(grid_load), .grid_store(grid_store),
    .grid_new_request(grid_new_request), .grid_fifo_full(grid_fifo_full),
    .grid_load_complete(grid_load_complete), .grid_load_data(grid_load_data),
    .lsu_rs1(lsu_rs1), .lsu_rs2(lsu_rs2), .lsu_fn3(lsu_fn3),
    .lsu_load(lsu_load), .lsu_store(lsu_store), .lsu_lock(lsu_lock),
    .lsu_ready(lsu_ready), .lsu_load_complete(lsu_load_complete),
    .lsu_load_data(lsu_load_data)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: issue entry {row[69:68], st[67], fn3[66:64], addr[63:32], data[31:0]}
  logic [69:0] exp_q[$];
  logic [33:0] ret_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic outstanding = 1'b0;
  logic [1:0] load_row = '0;

  int resp_delay = 1;          // 0 = random 1..3
  bit use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  int spurious_req = 0;
  int spurious_done = 0;

  logic [31:0] a_in [4];
  logic [31:0] d_in [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic rand_rows();
    for (int r = 0; r < 4; r++) begin
      a_in[r] = $urandom;
      d_in[r] = $urandom;
    end
  endtask

  // Called at posedge+1; drives one push cycle and returns at the next posedge+1.
  task automatic push(input logic [3:0] mask, input logic [3:0] st, input bit record);
    logic [2:0] f;
    check("push_allowed", {63'd0, grid_fifo_full}, 64'd0);
    for (int r = 0; r < 4; r++) begin
      f = 3'($urandom_range(0, 7));
      grid_addr[r] = a_in[r];
      grid_data[r] = d_in[r];
      grid_fn3[r]  = f;
      if (record && mask[r]) exp_q.push_back({2'(r), st[r], f, a_in[r], d_in[r]});
    end
    grid_store       = mask & st;
    grid_load        = mask & ~st;
    grid_new_request = mask;
    @(posedge clk); #1;
    grid_new_request = '0;
    grid_load        = '0;
    grid_store       = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0 || outstanding) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", {63'd0, n < budget}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("lock_released", {63'd0, lsu_lock}, 64'd0);
    @(posedge clk); #1;
  endtask

  // monitor: load returns and LSU issues
  initial begin
    logic [69:0] e;
    logic [33:0] rv;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (grid_load_complete != '0) begin
          if (ret_q.size() == 0) check("ret_unexpected", {60'd0, grid_load_complete}, 64'd0);
          else begin
            rv = ret_q.pop_front();
            check("ret_row", {60'd0, grid_load_complete}, {60'd0, 4'b0001 << rv[33:32]});
            check("ret_data", {32'd0, grid_load_data}, {32'd0, rv[31:0]});
          end
          outstanding = 1'b0;
        end
        if (lsu_load || lsu_store) begin
          check("issue_while_pending", {63'd0, outstanding}, 64'd0);
          if (exp_q.size() == 0) check("issue_unexpected", {63'd0, lsu_store}, {63'd0, ~lsu_store});
          else begin
            e = exp_q.pop_front();
            check("issue_kind", {62'd0, lsu_store, lsu_load}, {62'd0, e[67], ~e[67]});
            check("issue_fn3", {61'd0, lsu_fn3}, {61'd0, e[66:64]});
            check("issue_addr", {32'd0, lsu_rs1}, {32'd0, e[63:32]});
            if (e[67]) check("issue_data", {32'd0, lsu_rs2}, {32'd0, e[31:0]});
            load_row = e[69:68];
          end
          if (lsu_load) outstanding = 1'b1;
        end
      end
    end
  end

  // LSU responder
  initial begin
    int dly;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && lsu_load) begin
        dly = (resp_delay == 0) ? $urandom_range(1, 3) : resp_delay;
        @(posedge clk); #1;
        repeat (dly - 1) begin @(posedge clk); #1; end
        d = use_fixed ? fixed_data : $urandom;
        lsu_load_data     = d;
        lsu_load_complete = 1'b1;
        ret_q.push_back({load_row, d});
        @(posedge clk); #1;
        lsu_load_complete = 1'b0;
      end else if (spurious_req != spurious_done) begin
        @(posedge clk); #1;
        lsu_load_data     = $urandom;
        lsu_load_complete = 1'b1;
        @(posedge clk); #1;
        lsu_load_complete = 1'b0;
        spurious_done = spurious_req;
      end
    end
  end

  initial begin
    // 1: reset with three entries queued
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_rows();
    push(4'b0111, 4'b0101, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_lock", {63'd0, lsu_lock}, 64'd0);
    check("rst_full", {63'd0, grid_fifo_full}, 64'd0);
    check("rst_count", {60'd0, dut.count}, 64'd0);
    check("rst_complete", {60'd0, grid_load_complete}, 64'd0);
    check("rst_data", {32'd0, grid_load_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lsu_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_lock", {63'd0, lsu_lock}, 64'd0);
    check("post_rst_count", {60'd0, dut.count}, 64'd0);
    @(posedge clk); #1;

    // 2: row0 store, row2 load in one cycle
    rand_rows();
    a_in[0] = 32'h100; d_in[0] = 32'hAA; a_in[2] = 32'h200;
    use_fixed = 1'b1; fixed_data = 32'h1234; resp_delay = 1;
    push(4'b0101, 4'b0001, 1'b1);
    @(negedge clk);
    check("t2_lock", {63'd0, lsu_lock}, 64'd1);
    check("t2_store", {63'd0, lsu_store}, 64'd1);
    check("t2_rs1_store", {32'd0, lsu_rs1}, 64'h100);
    check("t2_rs2_store", {32'd0, lsu_rs2}, 64'hAA);
    @(negedge clk);
    check("t2_load", {63'd0, lsu_load}, 64'd1);
    check("t2_rs1_load", {32'd0, lsu_rs1}, 64'h200);
    @(posedge clk); #1;
    drain(50);
    check("t2_data_hold", {32'd0, grid_load_data}, 64'h1234);
    use_fixed = 1'b0;

    // 3: two full row sets with the LSU stalled
    lsu_ready = 1'b0; resp_delay = 0;
    rand_rows();
    push(4'b1111, 4'($urandom_range(0, 15)), 1'b1);
    check("t3_full_after_1", {63'd0, grid_fifo_full}, 64'd0);
    rand_rows();
    push(4'b1111, 4'($urandom_range(0, 15)), 1'b1);
    check("t3_full_after_2", {63'd0, grid_fifo_full}, 64'd1);
    check("t3_count", {60'd0, dut.count}, 64'd8);
    lsu_ready = 1'b1;
    drain(200);

    // 4: two loads, slow first return
    resp_delay = 5;
    rand_rows();
    push(4'b1010, 4'b0000, 1'b1);
    drain(100);

    // 5: full row set pushed in the same cycle the head issues at count=4
    resp_delay = 0;
    lsu_ready = 1'b0;
    rand_rows();
    push(4'b1111, 4'($urandom_range(0, 15)), 1'b1);
    lsu_ready = 1'b1;
    rand_rows();
    push(4'b1111, 4'($urandom_range(0, 15)), 1'b1);
    lsu_ready = 1'b0;
    check("t5_count", {60'd0, dut.count}, 64'd7);
    check("t5_full", {63'd0, grid_fifo_full}, 64'd1);
    lsu_ready = 1'b1;
    drain(200);

    // 6: spurious return with nothing pending
    spurious_req = spurious_req + 1;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_pulse", {60'd0, grid_load_complete}, 64'd0);
    end
    check("t6_lock", {63'd0, lsu_lock}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
